// File: rtl/input_buffer_pkg.sv
// Shared types for the UART-to-AES input path.
// Block layout: byte 0 (first received) sits in bits [127:120].
package input_buffer_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int BLOCK_BITS      = DATA_WIDTH * AES_BLOCK_BYTES;

  typedef logic [BLOCK_BITS-1:0] text_t;

  typedef enum logic {
    IBUF_COLLECT,
    IBUF_PENDING
  } in_buffer_fsm_e;

  // Write one byte into its big-endian slot of a block.
  function automatic text_t put_byte(
    input text_t                 blk,
    input logic [3:0]            idx,
    input logic [DATA_WIDTH-1:0] b
  );
    text_t r;
    r = blk;
    r[(AES_BLOCK_BYTES - 1 - int'(idx)) * DATA_WIDTH +: DATA_WIDTH] = b;
    return r;
  endfunction

endpackage

// File: rtl/input_buffer_asserts.sv
// Invariants of the input buffer, attached to its internal state.
// Pending implies a full assembly and an occupied hold register.
module input_buffer_asserts
  import input_buffer_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  input in_buffer_fsm_e state,
  input logic [3:0]     byte_index,
  input logic           hold_valid,
  input logic           buffer_write,
  input logic           fifo_full
);

  a_write: assert property (@(posedge clk) disable iff (!rst_n)
    buffer_write == (hold_valid && !fifo_full));

  a_pend: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IBUF_PENDING) |-> (byte_index == 4'd15 && hold_valid));

endmodule

// File: rtl/input_buffer.sv
// Assembles UART bytes into 128-bit blocks and feeds the AES input FIFO.
// One assembly register plus one holding register; stale partials time out.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  fifo_full,
  output logic                  buffer_write,
  output text_t                 text_out,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  in_buffer_fsm_e  state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  text_t           asm_q, asm_d;
  text_t           text_q, text_d;
  logic            hold_q, hold_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            hold_free;
  logic            load;
  text_t           load_val;
  text_t           asm_new;

  assign buffer_write = hold_q && !fifo_full;
  assign hold_free    = !hold_q || buffer_write;
  assign asm_new      = put_byte(asm_q, idx_q, rx_byte);
  assign text_out     = text_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign busy         = (idx_q != 4'd0) || (state_q == IBUF_PENDING) || hold_q;

  // Next-state: byte assembly, timeout, pending hand-off and hold register.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    text_d   = text_q;
    hold_d   = hold_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    load     = 1'b0;
    load_val = asm_q;
    unique case (state_q)
      IBUF_COLLECT: begin
        if (rx_done) begin
          asm_d = asm_new;
          cnt_d = '0;
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
          end else if (hold_free) begin
            load     = 1'b1;
            load_val = asm_new;
            idx_d    = 4'd0;
          end else begin
            state_d = IBUF_PENDING;
          end
        end else if (idx_q != 4'd0) begin
          if (cnt_q == CNT_LAST) begin
            idx_d  = 4'd0;
            cnt_d  = '0;
            ferr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IBUF_PENDING: begin
        if (rx_done) ovr_d = 1'b1;
        if (hold_free) begin
          load    = 1'b1;
          idx_d   = 4'd0;
          state_d = IBUF_COLLECT;
        end
      end
      default: state_d = IBUF_COLLECT;
    endcase
    if (load) begin
      text_d = load_val;
      hold_d = 1'b1;
    end else if (buffer_write) begin
      hold_d = 1'b0;
    end
  end

  // State registers; reset drops any partial or held block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IBUF_COLLECT;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      asm_q   <= '0;
      text_q  <= '0;
      hold_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      text_q  <= text_d;
      hold_q  <= hold_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer: queued expected blocks,
// monitor pops on every buffer_write.
module tb_input_buffer;
  import input_buffer_pkg::*;

  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       fifo_full = 1'b0;
  logic       buffer_write;
  text_t      text_out;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  text_t exp_q[$];

  input_buffer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done),
    .rx_byte(rx_byte), .fifo_full(fifo_full),
    .buffer_write(buffer_write), .text_out(text_out),
    .frame_error(frame_error), .overrun(overrun), .busy(busy)
  );

  bind input_buffer input_buffer_asserts u_asrt (
    .clk(clk), .rst_n(reset_n), .state(state_q),
    .byte_index(idx_q), .hold_valid(hold_q),
    .buffer_write(buffer_write), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (frame_error === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (buffer_write === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", text_out, 128'h0);
          if (text_out == 128'h0) begin
            fails++;
            $display("FAIL unexpected_write: got write, expected none");
          end
        end else begin
          check("block_data", text_out, exp_q.pop_front());
        end
      end
    end
  endtask

  function automatic text_t mk(input logic [7:0] s, input logic [7:0] st);
    text_t r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[(15 - i) * 8 +: 8] = s + st * 8'(i);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input text_t blk, input int first, input int last);
    for (int i = first; i <= last; i++)
      send_byte(blk[(15 - i) * 8 +: 8]);
  endtask

  text_t a, b, c, d, e, f, g, h;
  int w0, f0, o0;

  initial begin
    fork
      monitor_loop();
    join_none

    // reset state
    #12;
    check("rst_text", text_out, 128'h0);
    check("rst_bw", 128'(buffer_write), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_ferr", 128'(frame_error), 128'h0);
    check("rst_ovr", 128'(overrun), 128'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // nominal block
    a = mk(8'h00, 8'h11);
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    w0 = wr_cnt;
    send_bytes(a, 0, 14);
    check("nom_no_early_bw", 128'(buffer_write), 128'h0);
    send_bytes(a, 15, 15);
    check("nom_bw_latency", 128'(buffer_write), 128'h1);
    idle(2);
    check("nom_one_write", 128'(wr_cnt - w0), 128'd1);
    check("nom_busy_low", 128'(busy), 128'h0);

    // back-pressure and overrun
    b = mk(8'h20, 8'h01);
    c = mk(8'h40, 8'h03);
    fifo_full = 1'b1;
    w0 = wr_cnt;
    o0 = ovr_cnt;
    send_bytes(b, 0, 15);
    send_bytes(c, 0, 15);
    check("bp_busy", 128'(busy), 128'h1);
    send_byte(8'hEE);
    idle(1);
    check("bp_overrun", 128'(ovr_cnt - o0), 128'd1);
    check("bp_no_write", 128'(wr_cnt - w0), 128'd0);
    exp_q.push_back(b);
    exp_q.push_back(c);
    fifo_full = 1'b0;
    idle(1);
    check("bp_first_write", 128'(wr_cnt - w0), 128'd1);
    idle(1);
    check("bp_second_write", 128'(wr_cnt - w0), 128'd2);
    idle(2);
    check("bp_total_writes", 128'(wr_cnt - w0), 128'd2);
    check("bp_busy_low", 128'(busy), 128'h0);

    // timeout
    f0 = ferr_cnt;
    send_bytes(mk(8'hF0, 8'h01), 0, 4);
    idle(TO - 2);
    check("to_not_yet", 128'(ferr_cnt - f0), 128'd0);
    idle(4);
    check("to_ferr_once", 128'(ferr_cnt - f0), 128'd1);
    check("to_busy_low", 128'(busy), 128'h0);
    d = mk(8'h80, 8'h05);
    exp_q.push_back(d);
    w0 = wr_cnt;
    send_bytes(d, 0, 15);
    idle(2);
    check("to_next_block", 128'(wr_cnt - w0), 128'd1);

    // timeout race
    e = mk(8'h33, 8'h07);
    f0 = ferr_cnt;
    send_bytes(e, 0, 2);
    idle(TO - 1);
    send_bytes(e, 3, 3);
    idle(2);
    check("race_no_ferr", 128'(ferr_cnt - f0), 128'd0);
    check("race_busy", 128'(busy), 128'h1);
    exp_q.push_back(e);
    w0 = wr_cnt;
    send_bytes(e, 4, 15);
    idle(2);
    check("race_block", 128'(wr_cnt - w0), 128'd1);

    // reset mid-operation
    f = mk(8'hA5, 8'h0B);
    fifo_full = 1'b1;
    send_bytes(f, 0, 15);
    send_bytes(mk(8'h01, 8'h01), 0, 8);
    w0 = wr_cnt;
    reset_n = 1'b0;
    #2;
    check("mrst_text", text_out, 128'h0);
    check("mrst_busy", 128'(busy), 128'h0);
    fifo_full = 1'b0;
    #1;
    check("mrst_bw", 128'(buffer_write), 128'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    check("mrst_no_write", 128'(wr_cnt - w0), 128'd0);
    g = mk(8'h5A, 8'h13);
    exp_q.push_back(g);
    send_bytes(g, 0, 15);
    idle(2);
    check("mrst_next_block", 128'(wr_cnt - w0), 128'd1);

    // simultaneous write and load
    h = mk(8'hC0, 8'h02);
    fifo_full = 1'b1;
    w0 = wr_cnt;
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    send_bytes(g, 0, 15);
    send_bytes(h, 0, 14);
    exp_q.push_back(g);
    exp_q.push_back(h);
    fifo_full = 1'b0;
    send_bytes(h, 15, 15);
    check("sim_bw_after", 128'(buffer_write), 128'h1);
    check("sim_text_reload", text_out, h);
    send_byte(8'h77);
    idle(1);
    check("sim_no_pending", 128'(ovr_cnt - o0), 128'd0);
    check("sim_writes", 128'(wr_cnt - w0), 128'd2);
    idle(TO + 2);
    check("sim_partial_to", 128'(ferr_cnt - f0), 128'd1);

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    check("total_overruns", 128'(ovr_cnt), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Upstream neighbour of the output buffer's counterpart path. Assembles UART-received bytes into 128-bit plaintext blocks and pushes each block into the input FIFO that feeds the AES-128 core.
- Double-buffered: one 16-byte assembly register plus one holding register. Reception continues while a finished block waits on a full FIFO.
- Partial blocks are discarded after an inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, UART byte width (localparam, fixed).
- BLOCK_BYTES, 16, bytes per AES block (localparam, fixed).
- TIMEOUT_CYCLES, 65536, idle clocks allowed between bytes of a partial block before it is discarded.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_done  in  1  one-cycle pulse; rx_byte is valid in that cycle.
- rx_byte  in  8  received UART byte.
- fifo_full  in  1  input FIFO full flag.
- buffer_write  out  1  FIFO write strobe.
- text_out  out  128 (text_t)  block presented to the FIFO; byte 0 is the first byte received.
- frame_error  out  1  one-cycle pulse when a partial block times out.
- overrun  out  1  one-cycle pulse when a byte is dropped.
- busy  out  1  partial block, pending block, or held block present.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: state=IBUF_COLLECT, byte_index=0, timeout counter=0, assembly=0, text_out=0, hold_valid=0, frame_error=0, overrun=0. Derived outputs at reset: buffer_write=0, busy=0.
- FSM state IBUF_COLLECT:
  - On rx_done, write rx_byte into assembly[byte_index] and clear the timeout counter.
  - If byte_index<15, increment byte_index.
  - If byte_index==15, the block is complete:
    - If hold is free (hold_valid==0, or buffer_write is high this cycle), load text_out from the assembly (including this byte), set hold_valid, set byte_index=0, stay in IBUF_COLLECT.
    - Otherwise go to IBUF_PENDING with byte_index=15.
- FSM state IBUF_PENDING:
  - Any rx_done drops the byte and pulses overrun the next cycle.
  - When hold becomes free, load text_out from the assembly, set hold_valid, set byte_index=0, return to IBUF_COLLECT. This takes one cycle.
- Hold side:
  - buffer_write = hold_valid && !fifo_full, combinational.
  - On a clock edge with buffer_write high, the FIFO captures text_out and hold_valid clears.
  - If a new load happens on that same edge, hold_valid stays set.
- Latency: 16th rx_done sampled at edge k with hold empty → text_out valid after k. If fifo_full==0, buffer_write is high during cycle k..k+1 and the write is captured at edge k+1.
- Timeout:
  - The counter increments each cycle in IBUF_COLLECT while byte_index!=0 and rx_done==0.
  - At TIMEOUT_CYCLES-1, set byte_index=0, clear the counter and pulse frame_error. The assembly contents are don't-care.
  - rx_done in the expiry cycle wins: the byte is accepted and no error is raised.
  - No timeout in IBUF_PENDING or while byte_index==0.
- busy = (byte_index!=0) || (state==IBUF_PENDING) || hold_valid.
- text_out is stable whenever hold_valid==1 and changes only on a load.
- Reset mid-block or mid-stall: all state is lost immediately, and a pending block is not written.

Decomposition:
- DesignPkg gains enum in_buffer_fsm_e {IBUF_COLLECT, IBUF_PENDING}.
- DesignPkg gains the constant AES_BLOCK_BYTES=16.
- text_t is reused from DesignPkg.
- No sub-module. A companion assertion module, input_buffer_asserts, binds to state, byte_index, hold_valid, buffer_write, fifo_full.

Test Plan:
- Nominal block: 16 bytes 00,11,...,ff with fifo_full=0 → one buffer_write pulse one cycle after the 16th rx_done; text_out=00112233445566778899aabbccddeeff; busy low afterwards.
- Back-pressure: fifo_full=1, send block A, then block B → A held, B reaches IBUF_PENDING; a 33rd byte causes an overrun pulse. Release fifo_full → A written, then B written one cycle later (loaded the cycle after A's write); no other pulses.
- Timeout: send 5 bytes, then idle TIMEOUT_CYCLES → frame_error pulses once, byte_index=0. The next 16 bytes produce a correct block with no stale data in byte order.
- Timeout race: rx_done coincides with the expiry cycle → no frame_error, and byte_index increments.
- Reset mid-operation: assert reset_n=0 after 9 bytes and with a block held → all outputs zero immediately. No buffer_write after release; the next full block is assembled correctly.
- Simultaneous write and load: hold full, fifo_full drops in the same cycle as the 16th byte → buffer_write high, hold reloaded on that edge, hold_valid remains 1, no IBUF_PENDING entry.
